// File: rtl/fetch_ctrl_if.sv
// Bundles the imem request/response channel and the IF/ID output channel.
// master = fetch controller side, slave = memory / downstream side.
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding imem request, PC step/redirect control,
// stale-response discard after redirects and a sticky imem timeout flag.
module fetch_ctrl #(
  parameter int          XLEN        = 32,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  output logic            pc_en,
  output logic            pc_stall,
  output logic            fetch_err,
  fetch_ctrl_if.master    bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD, S_ERR} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t          state, state_nxt;
  logic [15:0]     cnt, cnt_nxt;
  logic [XLEN-1:0] pc_q;
  logic            req_v, fire, timeout, load_if, clr_if, set_err;
  logic            if_v_q, err_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] if_pc_q;

  // Counter value before this edge; reaching TIMEOUT_CYC on this edge is a timeout.
  assign timeout = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_v     = 1'b0;
    fire      = 1'b0;
    load_if   = 1'b0;
    clr_if    = 1'b0;
    set_err   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        req_v   = ~redirect_valid;
        fire    = req_v & bus.imem_req_ready;
        cnt_nxt = '0;
        if (fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + 16'd1;
        if (bus.imem_rsp_valid && !redirect_valid) begin
          load_if   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_HOLD;
        end else if (bus.imem_rsp_valid) begin
          cnt_nxt   = '0;
          state_nxt = S_REQ;
        end else if (timeout) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        // Response belongs to a squashed fetch; redirects here only reload PC.
        cnt_nxt = cnt + 16'd1;
        if (bus.imem_rsp_valid) begin
          cnt_nxt   = '0;
          state_nxt = S_REQ;
        end else if (timeout) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end
      end
      S_HOLD: begin
        if (bus.if_ready || redirect_valid) begin
          clr_if    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pc_en              = (state != S_IDLE) && (state != S_ERR) && (fire || redirect_valid);
  assign pc_stall           = ~pc_en;
  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = if_v_q;
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = if_pc_q;
  assign fetch_err          = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pc_q    <= '0;
      if_v_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fire) pc_q <= pc;
      if (load_if) begin
        if_v_q  <= 1'b1;
        instr_q <= bus.imem_rsp_data;
        if_pc_q <= pc_q;
      end else if (clr_if) begin
        if_v_q <= 1'b0;
      end
      if (set_err) err_q <= 1'b1;
    end
  end
endmodule
